scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Drives one scan chain of mux-D scan flops through a full load/capture/unload sequence: shift-in, capture, shift-out.
- Sources the chain's SE and SI and sinks its SO (Q of the last flop).
- Loads a parallel stimulus pattern, returns the parallel captured response, and flags a mismatch against an expected value.
- Sits between the on-chip test sequencer and each scan chain.

Parameters:
- CHAIN_LEN, 16, number of flops in the chain (≥2).
- CAP_CYCLES, 1, functional capture cycles with SE=0 (≥1).
- FILL, 1'b0, SI value driven during shift-out.
- CNT_W, $clog2(CHAIN_LEN+1), internal counter width; derived, do not override.

Ports:
- CLK  in  1  clock; the chain flops use the same edge.
- RSTB  in  1  asynchronous active-low reset.
- start  in  1  request a sequence; sampled only in IDLE.
- pattern  in  CHAIN_LEN  stimulus; bit i lands in flop i (flop CHAIN_LEN-1 is nearest SO).
- expected  in  CHAIN_LEN  expected captured response; sampled with start.
- scan_so  in  1  chain output.
- scan_se  out  1  scan enable to chain.
- scan_si  out  1  scan data to chain.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- result  out  CHAIN_LEN  unloaded response, same bit mapping as pattern.
- mismatch  out  1  result != expected; valid with done, held until next start.
- pass_cnt  out  16  count of sequences without mismatch, saturating at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): state=IDLE; scan_se=0, scan_si=0, busy=0, done=0, result=0, mismatch=0, pass_cnt=0.
- All outputs are registered.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE, start=1 at edge t0:
  - latch pattern and expected;
  - go to SHIFT_IN; scan_se=1, scan_si=pattern[CHAIN_LEN-1]; busy=1.
- SHIFT_IN:
  - each edge advances scan_si to the next lower pattern bit, MSB first.
  - After CHAIN_LEN shift edges (t1..tN, N=CHAIN_LEN), at tN go to CAPTURE with scan_se=0.
- CAPTURE:
  - holds for CAP_CYCLES edges; scan_si keeps its last value.
  - At the final capture edge, go to SHIFT_OUT with scan_se=1 and scan_si=FILL.
- SHIFT_OUT:
  - samples scan_so on each of CHAIN_LEN edges into a left-shift register: result <= {result[CHAIN_LEN-2:0], scan_so}.
  - The first sample is flop CHAIN_LEN-1.
  - On the last sample edge, go to DONE; scan_se=0; mismatch computed from the final result.
- DONE:
  - one cycle with done=1 and busy=1.
  - If mismatch=0, pass_cnt increments (saturating).
  - Next edge returns to IDLE with busy=0 and done=0.
- result updates only during SHIFT_OUT.
  - Between sequences it holds the last value.
  - Intermediate values are visible while busy=1.
- Latency, start edge to done high: 2·CHAIN_LEN + CAP_CYCLES + 1 edges.
- start while busy (including in DONE): ignored; no queuing.
- pattern/expected changing after the start edge: no effect.
- RSTB asserted mid-sequence: immediate return to reset values; chain content is undefined and the host must restart.
- Counter: one CNT_W down-counter reused for each phase, reloaded on every state entry; no wrap beyond the phase length.

Decomposition:
- Package scan_pkg holds:
  - the state enum (scan_state_t) with explicit 3-bit encoding;
  - localparam PASS_CNT_W=16;
  - a function computing CNT_W.
- One sub-module, scan_shift_reg: CHAIN_LEN-bit register with parallel load and serial-out MSB (PISO) on load/shift_in. The same instance with serial-in LSB (SIPO) is used for the response during SHIFT_OUT.

Test Plan:
- CHAIN_LEN=4, CAP_CYCLES=1; bench chain of 4 scan flops with D tied to a bench-driven capture vector.
- Reset: hold RSTB=0 with start=1 → all outputs 0. Release, start pulse → scan_se rises the next cycle; scan_si sequence 1,0,1,1 for pattern=4'b1011.
- Capture check: pattern=4'b1011, capture vector 4'b0110, expected=4'b0110 → scan_se low for exactly 1 cycle; done asserted 10 edges after start; result=4'b0110, mismatch=0, pass_cnt=1.
- Mismatch: capture vector 4'b0111, expected=4'b0110 → result=4'b0111, mismatch=1, pass_cnt unchanged; mismatch held until next start.
- Start ignored: pulse start at cycles 3 and 9 (DONE) of a running sequence → exactly one done pulse; next sequence begins only on a start sampled in IDLE.
- Reset mid-SHIFT_OUT: drop RSTB at edge 7 → scan_se=0, busy=0, result=0 immediately. A subsequent sequence with pattern=4'b0000 and capture 4'b1001 returns result=4'b1001.
- Saturation: force pass_cnt to 16'hFFFE via 2 preloaded passing runs in a bench-only build (or a long run) → pass_cnt reaches 16'hFFFF and stays there on further passes.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan chain controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } scan_state_t;

  localparam int PASS_CNT_W = 16;

  function automatic int scan_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-shift register; shifts toward the MSB with new data at the LSB.
// Used both as a PISO (read the MSB) and as a SIPO (read the whole vector).
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[WIDTH-2:0], ser_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Runs one scan chain through shift-in, capture and shift-out, returning the
// unloaded response and a compare flag against the expected vector.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int   CHAIN_LEN  = 16,
  parameter int   CAP_CYCLES = 1,
  parameter logic FILL       = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  start,
  input  logic [CHAIN_LEN-1:0]  pattern,
  input  logic [CHAIN_LEN-1:0]  expected,
  input  logic                  scan_so,
  output logic                  scan_se,
  output logic                  scan_si,
  output logic                  busy,
  output logic                  done,
  output logic [CHAIN_LEN-1:0]  result,
  output logic                  mismatch,
  output logic [PASS_CNT_W-1:0] pass_cnt
);

  // The shared phase counter must also hold the capture length.
  localparam int CNT_W = scan_cnt_w((CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES);

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  se_q, se_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mismatch_q, mismatch_d;
  logic [PASS_CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CHAIN_LEN-1:0]  expected_q, expected_d;

  logic                  stim_load;
  logic [CHAIN_LEN-1:0]  stim_val;
  logic                  stim_shift;
  logic                  resp_shift;
  logic [CHAIN_LEN-1:0]  stim_q;
  logic [CHAIN_LEN-1:0]  result_q;
  logic [CHAIN_LEN-1:0]  result_final;
  logic                  stim_unused;

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_stim (
    .clk_i      (CLK),
    .rst_ni     (RSTB),
    .load_i     (stim_load),
    .load_val_i (stim_val),
    .shift_i    (stim_shift),
    .ser_i      (FILL),
    .q_o        (stim_q)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_resp (
    .clk_i      (CLK),
    .rst_ni     (RSTB),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (resp_shift),
    .ser_i      (scan_so),
    .q_o        (result_q)
  );

  // Only the MSB of the stimulus register drives the chain.
  assign stim_unused  = ^stim_q[CHAIN_LEN-2:0];
  assign result_final = {result_q[CHAIN_LEN-2:0], scan_so};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    se_d       = se_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    pass_cnt_d = pass_cnt_q;
    expected_d = expected_q;
    stim_load  = 1'b0;
    stim_val   = pattern;
    stim_shift = 1'b0;
    resp_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = SHIFT_IN;
          cnt_d      = CNT_W'(CHAIN_LEN);
          se_d       = 1'b1;
          busy_d     = 1'b1;
          mismatch_d = 1'b0;
          expected_d = expected;
          stim_load  = 1'b1;
        end
      end
      SHIFT_IN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = CAPTURE;
          cnt_d   = CNT_W'(CAP_CYCLES);
          se_d    = 1'b0;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          stim_shift = 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = SHIFT_OUT;
          cnt_d     = CNT_W'(CHAIN_LEN);
          se_d      = 1'b1;
          stim_load = 1'b1;
          stim_val  = {CHAIN_LEN{FILL}};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT_OUT: begin
        resp_shift = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          cnt_d      = '0;
          se_d       = 1'b0;
          done_d     = 1'b1;
          mismatch_d = (result_final != expected_q);
          if ((result_final == expected_q) && (pass_cnt_q != '1)) begin
            pass_cnt_d = pass_cnt_q + PASS_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        se_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      pass_cnt_q <= '0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      se_q       <= se_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      pass_cnt_q <= pass_cnt_d;
      expected_q <= expected_d;
    end
  end

  assign scan_se  = se_q;
  assign scan_si  = stim_q[CHAIN_LEN-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mismatch = mismatch_q;
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 4-flop mux-D chain model; expected responses
// are queued at start and checked by a monitor on each done pulse.
module tb_scan_chain_ctrl;

  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        start = 1'b1;
  logic [3:0]  pattern = '0;
  logic [3:0]  expected = '0;
  logic        scan_so;
  logic        scan_se;
  logic        scan_si;
  logic        busy;
  logic        done;
  logic [3:0]  result;
  logic        mismatch;
  logic [15:0] pass_cnt;

  logic [3:0]  chain_q = '0;
  logic [3:0]  cap_vec = '0;
  logic [15:0] pass_model = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_seq = 0;

  typedef struct packed {
    logic [3:0]  res;
    logic        mm;
    logic [15:0] pc;
  } exp_t;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(1), .FILL(1'b0)) dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .start    (start),
    .pattern  (pattern),
    .expected (expected),
    .scan_so  (scan_so),
    .scan_se  (scan_se),
    .scan_si  (scan_si),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mismatch (mismatch),
    .pass_cnt (pass_cnt)
  );

  // Mux-D chain: flop 0 takes SI, flop 3 drives SO.
  always @(posedge CLK) begin
    if (scan_se) chain_q <= {chain_q[2:0], scan_si};
    else         chain_q <= cap_vec;
  end
  assign scan_so = chain_q[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTB && done) begin
      exp_t e;
      n_seq++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, want no pending sequence (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("mismatch", 32'(mismatch), 32'(e.mm));
        chk("pass_cnt", 32'(pass_cnt), 32'(e.pc));
        $display("seq %0d: result=%b mismatch=%b pass_cnt=%h (want %b/%b/%h)",
                 n_seq, result, mismatch, pass_cnt, e.res, e.mm, e.pc);
      end
    end
  end

  // One sequence; inj pulses start during busy, abort_edge>0 drops RSTB just after that edge.
  task automatic run_seq(input logic [3:0] pat, input logic [3:0] cap, input logic [3:0] exv,
                         input bit inj, input int abort_edge);
    exp_t e;
    @(negedge CLK);
    pattern  = pat;
    expected = exv;
    cap_vec  = cap;
    start    = 1'b1;
    if (abort_edge == 0) begin
      e.res = cap;
      e.mm  = (cap != exv);
      if (!e.mm && pass_model != 16'hFFFF) pass_model = pass_model + 16'd1;
      e.pc  = pass_model;
      sb_q.push_back(e);
    end
    for (int k = 0; k <= 10; k++) begin
      if (abort_edge != 0 && k == abort_edge) begin
        @(posedge CLK);
        #2 RSTB = 1'b0;
        #1;
        chk("rst_mid_se", 32'(scan_se), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_result", 32'(result), 32'd0);
        chk("rst_mid_pass_cnt", 32'(pass_cnt), 32'd0);
        pass_model = '0;
        @(negedge CLK);
        RSTB = 1'b1;
        return;
      end
      @(negedge CLK);
      start    = inj && (k == 3 || k == 9);
      pattern  = ~pat;
      expected = ~exv;
      if (k <= 3) begin
        chk($sformatf("si_c%0d", k), 32'(scan_si), 32'(pat[3-k]));
        chk($sformatf("se_c%0d", k), 32'(scan_se), 32'd1);
        chk($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
      end else if (k == 4) begin
        chk("se_capture", 32'(scan_se), 32'd0);
        chk("chain_loaded", 32'(chain_q), 32'(pat));
        chk("si_hold", 32'(scan_si), 32'(pat[0]));
      end else if (k == 5) begin
        chk("se_shift_out", 32'(scan_se), 32'd1);
        chk("si_fill", 32'(scan_si), 32'd0);
      end else if (k == 8) begin
        chk("done_early", 32'(done), 32'd0);
      end else if (k == 9) begin
        chk("done_latency", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("se_done", 32'(scan_se), 32'd0);
      end else if (k == 10) begin
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_se", 32'(scan_se), 32'd0);
    chk("rst_si", 32'(scan_si), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    RSTB  = 1'b1;
    start = 1'b0;

    run_seq(4'b1011, 4'b0110, 4'b0110, 1'b0, 0);
    run_seq(4'b1011, 4'b0111, 4'b0110, 1'b0, 0);
    repeat (3) @(negedge CLK);
    chk("mismatch_held", 32'(mismatch), 32'd1);
    chk("result_held", 32'(result), 32'b0111);

    run_seq(4'b0101, 4'b1010, 4'b1010, 1'b1, 0);
    repeat (12) @(negedge CLK);
    chk("no_restart_busy", 32'(busy), 32'd0);

    run_seq(4'b1011, 4'b1111, 4'b1111, 1'b0, 7);
    run_seq(4'b0000, 4'b1001, 4'b1001, 1'b0, 0);

    @(negedge CLK);
    force dut.pass_cnt_q = 16'hFFFE;
    #1 release dut.pass_cnt_q;
    pass_model = 16'hFFFE;
    run_seq(4'b1100, 4'b0011, 4'b0011, 1'b0, 0);
    run_seq(4'b0011, 4'b1100, 4'b1100, 1'b0, 0);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("done_count", 32'(n_seq), 32'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
